// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential advance, conditional branches on the ALU
// result, and memory-sourced targets fetched through a valid handshake.
module pc_sequencer #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] aluout,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] direct,
    input  logic [WIDTH-1:0] pcimm,
    input  logic             zero_branch,
    input  logic             mem_valid,
    input  logic [WIDTH-1:0] memout,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic             mem_req,
    output logic             taken,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic             align_err
);

    localparam logic [2:0] MODE_BRZ = 3'b001;
    localparam logic [2:0] MODE_BMN = 3'b010;
    localparam logic [2:0] MODE_JMP = 3'b011;
    localparam logic [2:0] MODE_BZ  = 3'b100;
    localparam logic [2:0] MODE_BEQ = 3'b101;

    typedef enum logic {
        ST_RUN,
        ST_WAIT_MEM
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pcNext;
    logic [WIDTH-1:0] w_pc4;
    logic             w_pcLoad;
    logic             w_takeLoad;
    logic             w_branchEval;
    logic             w_n;
    logic             w_z;
    logic             r_taken;
    logic [CNT_W-1:0] r_branchCnt;
    logic [CNT_W-1:0] r_takenCnt;
    logic             r_alignErr;

    assign w_n   = aluout[WIDTH-1];
    assign w_z   = (aluout == '0);
    assign w_pc4 = r_pc + WIDTH'(4);

    // Memory-sourced targets (jump, or bmn when negative) park in WAIT_MEM with pc held.
    always_comb begin
        w_stateNext  = r_state;
        w_pcNext     = r_pc;
        w_pcLoad     = 1'b0;
        w_takeLoad   = 1'b0;
        w_branchEval = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (en) begin
                    w_pcLoad = 1'b1;
                    w_pcNext = w_pc4;
                    case (mode)
                        MODE_BRZ: begin
                            w_branchEval = 1'b1;
                            if (w_z) begin
                                w_pcNext   = reg1;
                                w_takeLoad = 1'b1;
                            end
                        end
                        MODE_BMN: begin
                            w_branchEval = 1'b1;
                            if (w_n) begin
                                w_pcLoad    = 1'b0;
                                w_stateNext = ST_WAIT_MEM;
                            end
                        end
                        MODE_JMP: begin
                            w_branchEval = 1'b1;
                            w_pcLoad     = 1'b0;
                            w_stateNext  = ST_WAIT_MEM;
                        end
                        MODE_BZ: begin
                            w_branchEval = 1'b1;
                            if (w_z) begin
                                w_pcNext   = direct;
                                w_takeLoad = 1'b1;
                            end
                        end
                        MODE_BEQ: begin
                            w_branchEval = 1'b1;
                            if (zero_branch) begin
                                w_pcNext   = pcimm;
                                w_takeLoad = 1'b1;
                            end
                        end
                        default: begin
                            w_branchEval = 1'b0;
                        end
                    endcase
                end
            end
            ST_WAIT_MEM: begin
                if (mem_valid) begin
                    w_pcLoad    = 1'b1;
                    w_pcNext    = memout;
                    w_takeLoad  = 1'b1;
                    w_stateNext = ST_RUN;
                end
            end
            default: begin
                w_stateNext = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_taken <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_taken <= w_takeLoad;
            if (w_pcLoad) begin
                r_pc <= w_pcNext;
            end
        end
    end

    // Statistics saturate instead of wrapping so long runs never read as short ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branchCnt <= '0;
            r_takenCnt  <= '0;
            r_alignErr  <= 1'b0;
        end else begin
            if (w_branchEval && (r_branchCnt != {CNT_W{1'b1}})) begin
                r_branchCnt <= r_branchCnt + CNT_W'(1);
            end
            if (w_takeLoad && (r_takenCnt != {CNT_W{1'b1}})) begin
                r_takenCnt <= r_takenCnt + CNT_W'(1);
            end
            if (w_takeLoad && (w_pcNext[1:0] != 2'b00)) begin
                r_alignErr <= 1'b1;
            end
        end
    end

    assign pc         = r_pc;
    assign pc_valid   = (r_state == ST_RUN);
    assign mem_req    = (r_state == ST_WAIT_MEM);
    assign taken      = r_taken;
    assign branch_cnt = r_branchCnt;
    assign taken_cnt  = r_takenCnt;
    assign align_err  = r_alignErr;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written
// reset/saturation sequences, and randomized traffic against a reference model.
module tb_pc_sequencer;

    localparam logic [31:0] JR = 32'h0000_0A00;
    localparam logic [31:0] JD = 32'h0000_0B00;
    localparam logic [31:0] JP = 32'h0000_0C00;
    localparam logic [31:0] JM = 32'h0000_0D00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [31:0] aluout = 32'd0;
    logic [31:0] reg1 = 32'd0;
    logic [31:0] direct = 32'd0;
    logic [31:0] pcimm = 32'd0;
    logic        zero_branch = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] memout = 32'd0;

    logic [31:0] pc;
    logic        pc_valid;
    logic        mem_req;
    logic        taken;
    logic [15:0] branch_cnt;
    logic [15:0] taken_cnt;
    logic        align_err;

    logic [31:0] sPc;
    logic        sPcValid;
    logic        sMemReq;
    logic        sTaken;
    logic [1:0]  sBranchCnt;
    logic [1:0]  sTakenCnt;
    logic        sAlignErr;

    int assertCount = 0;
    int failCount = 0;

    typedef struct {
        logic        en;
        logic [2:0]  mode;
        logic [31:0] alu;
        logic [31:0] r1;
        logic [31:0] dr;
        logic [31:0] pi;
        logic        zb;
        logic        mv;
        logic [31:0] mo;
        logic [31:0] ePc;
        logic        eTaken;
        logic        eMemReq;
        int          eBr;
        int          eTk;
        logic        eAlign;
    } vec_t;

    vec_t vecs[$];

    logic [31:0] mPc;
    bit          mWait;
    bit          mTakenOut;
    bit          mAlign;
    int          mBr;
    int          mTk;

    pc_sequencer #(.WIDTH(32), .RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .aluout(aluout),
        .reg1(reg1), .direct(direct), .pcimm(pcimm), .zero_branch(zero_branch),
        .mem_valid(mem_valid), .memout(memout), .pc(pc), .pc_valid(pc_valid),
        .mem_req(mem_req), .taken(taken), .branch_cnt(branch_cnt),
        .taken_cnt(taken_cnt), .align_err(align_err)
    );

    pc_sequencer #(.WIDTH(32), .RESET_PC(32'h40), .CNT_W(2)) dutSat (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .aluout(aluout),
        .reg1(reg1), .direct(direct), .pcimm(pcimm), .zero_branch(zero_branch),
        .mem_valid(mem_valid), .memout(memout), .pc(sPc), .pc_valid(sPcValid),
        .mem_req(sMemReq), .taken(sTaken), .branch_cnt(sBranchCnt),
        .taken_cnt(sTakenCnt), .align_err(sAlignErr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic e, input logic [2:0] m, input logic [31:0] a,
                                input logic [31:0] r1, input logic [31:0] dr, input logic [31:0] pi,
                                input logic zb, input logic mv, input logic [31:0] mo,
                                input logic [31:0] ePc, input logic eT, input logic eM,
                                input int eBr, input int eTk, input logic eA);
        vec_t v;
        v.en = e; v.mode = m; v.alu = a; v.r1 = r1; v.dr = dr; v.pi = pi;
        v.zb = zb; v.mv = mv; v.mo = mo; v.ePc = ePc; v.eTaken = eT;
        v.eMemReq = eM; v.eBr = eBr; v.eTk = eTk; v.eAlign = eA;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        en = v.en; mode = v.mode; aluout = v.alu; reg1 = v.r1; direct = v.dr;
        pcimm = v.pi; zero_branch = v.zb; mem_valid = v.mv; memout = v.mo;
    endtask

    task automatic checkVector(input vec_t v, input int i);
        checkOutput($sformatf("vec%0d pc", i), 64'(pc), 64'(v.ePc));
        checkOutput($sformatf("vec%0d taken", i), 64'(taken), 64'(v.eTaken));
        checkOutput($sformatf("vec%0d mem_req", i), 64'(mem_req), 64'(v.eMemReq));
        checkOutput($sformatf("vec%0d pc_valid", i), 64'(pc_valid), 64'(!v.eMemReq));
        checkOutput($sformatf("vec%0d branch_cnt", i), 64'(branch_cnt), 64'(v.eBr));
        checkOutput($sformatf("vec%0d taken_cnt", i), 64'(taken_cnt), 64'(v.eTk));
        checkOutput($sformatf("vec%0d align_err", i), 64'(align_err), 64'(v.eAlign));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " pc"}, 64'(pc), 64'h0);
        checkOutput({tag, " pc_valid"}, 64'(pc_valid), 64'h1);
        checkOutput({tag, " mem_req"}, 64'(mem_req), 64'h0);
        checkOutput({tag, " taken"}, 64'(taken), 64'h0);
        checkOutput({tag, " branch_cnt"}, 64'(branch_cnt), 64'h0);
        checkOutput({tag, " taken_cnt"}, 64'(taken_cnt), 64'h0);
        checkOutput({tag, " align_err"}, 64'(align_err), 64'h0);
        checkOutput({tag, " sat pc"}, 64'(sPc), 64'h40);
        checkOutput({tag, " sat pc_valid"}, 64'(sPcValid), 64'h1);
        checkOutput({tag, " sat mem_req"}, 64'(sMemReq), 64'h0);
        checkOutput({tag, " sat taken"}, 64'(sTaken), 64'h0);
        checkOutput({tag, " sat branch_cnt"}, 64'(sBranchCnt), 64'h0);
        checkOutput({tag, " sat taken_cnt"}, 64'(sTakenCnt), 64'h0);
        checkOutput({tag, " sat align_err"}, 64'(sAlignErr), 64'h0);
    endtask

    task automatic doReset();
        en = 1'b0;
        mem_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] randTarget();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 3) != 0) begin
            t[1:0] = 2'b00;
        end
        return t;
    endfunction

    function automatic longint sat16(input int c);
        return (c > 65535) ? 65535 : c;
    endfunction

    // Reference: what the program counter should do this cycle, stated directly.
    task automatic modelStep();
        bit          isBranch;
        bit          toMemory;
        bit          cond;
        logic [31:0] tgt;
        mTakenOut = 0;
        if (mWait) begin
            if (mem_valid) begin
                mPc = memout;
                mTakenOut = 1;
                mWait = 0;
            end
        end else if (en) begin
            isBranch = (mode >= 3'd1) && (mode <= 3'd5);
            toMemory = (mode == 3'd3) || ((mode == 3'd2) && aluout[31]);
            cond = ((mode == 3'd1) && (aluout == 0)) || ((mode == 3'd4) && (aluout == 0))
                   || ((mode == 3'd5) && zero_branch);
            tgt = (mode == 3'd1) ? reg1 : (mode == 3'd4) ? direct : pcimm;
            if (isBranch) mBr++;
            if (toMemory) mWait = 1;
            else if (cond) begin
                mPc = tgt;
                mTakenOut = 1;
            end else mPc = mPc + 32'd4;
        end
        if (mTakenOut) begin
            mTk++;
            if (mPc[1:0] != 2'b00) mAlign = 1;
        end
    endtask

    task automatic checkModel(input int c);
        checkOutput($sformatf("rnd%0d pc", c), 64'(pc), 64'(mPc));
        checkOutput($sformatf("rnd%0d taken", c), 64'(taken), 64'(mTakenOut));
        checkOutput($sformatf("rnd%0d mem_req", c), 64'(mem_req), 64'(mWait));
        checkOutput($sformatf("rnd%0d pc_valid", c), 64'(pc_valid), 64'(!mWait));
        checkOutput($sformatf("rnd%0d branch_cnt", c), 64'(branch_cnt), 64'(sat16(mBr)));
        checkOutput($sformatf("rnd%0d taken_cnt", c), 64'(taken_cnt), 64'(sat16(mTk)));
        checkOutput($sformatf("rnd%0d align_err", c), 64'(align_err), 64'(mAlign));
    endtask

    initial begin
        vecs.push_back(mk(1, 3'd0, 32'd5, JR, JD, JP, 0, 0, JM, 32'h4, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'd0, 32'd5, JR, JD, JP, 0, 0, JM, 32'h8, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'd0, 32'd5, JR, JD, JP, 0, 0, JM, 32'hC, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'd0, 32'd5, JR, JD, JP, 0, 0, JM, 32'h10, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'd1, 32'd0, 32'h100, JD, JP, 0, 0, JM, 32'h100, 1, 0, 1, 1, 0));
        vecs.push_back(mk(1, 3'd1, 32'd5, 32'h100, JD, JP, 0, 0, JM, 32'h104, 0, 0, 2, 1, 0));
        vecs.push_back(mk(0, 3'd1, 32'd0, 32'h100, JD, JP, 0, 0, JM, 32'h104, 0, 0, 2, 1, 0));
        vecs.push_back(mk(1, 3'd2, 32'h8000_0000, JR, JD, JP, 0, 0, JM, 32'h104, 0, 1, 3, 1, 0));
        vecs.push_back(mk(1, 3'd0, 32'd5, JR, JD, JP, 0, 0, JM, 32'h104, 0, 1, 3, 1, 0));
        vecs.push_back(mk(1, 3'd1, 32'd0, JR, JD, JP, 0, 0, JM, 32'h104, 0, 1, 3, 1, 0));
        vecs.push_back(mk(1, 3'd0, 32'd5, JR, JD, JP, 0, 0, JM, 32'h104, 0, 1, 3, 1, 0));
        vecs.push_back(mk(1, 3'd0, 32'd5, JR, JD, JP, 0, 1, 32'h200, 32'h200, 1, 0, 3, 2, 0));
        vecs.push_back(mk(1, 3'd2, 32'd5, JR, JD, JP, 0, 0, JM, 32'h204, 0, 0, 4, 2, 0));
        vecs.push_back(mk(1, 3'd3, 32'd5, JR, JD, JP, 0, 1, 32'h300, 32'h204, 0, 1, 5, 2, 0));
        vecs.push_back(mk(0, 3'd0, 32'd5, JR, JD, JP, 0, 1, 32'h300, 32'h300, 1, 0, 5, 3, 0));
        vecs.push_back(mk(1, 3'd5, 32'd5, JR, JD, 32'h304, 1, 0, JM, 32'h304, 1, 0, 6, 4, 0));
        vecs.push_back(mk(1, 3'd5, 32'd5, JR, JD, JP, 0, 0, JM, 32'h308, 0, 0, 7, 4, 0));
        vecs.push_back(mk(1, 3'd6, 32'd0, JR, JD, JP, 1, 0, JM, 32'h30C, 0, 0, 7, 4, 0));
        vecs.push_back(mk(1, 3'd7, 32'd0, JR, JD, JP, 1, 0, JM, 32'h310, 0, 0, 7, 4, 0));
        vecs.push_back(mk(1, 3'd4, 32'd0, JR, 32'h102, JP, 0, 0, JM, 32'h102, 1, 0, 8, 5, 1));
        vecs.push_back(mk(1, 3'd0, 32'd5, JR, JD, JP, 0, 0, JM, 32'h106, 0, 0, 8, 5, 1));
        vecs.push_back(mk(1, 3'd4, 32'd0, JR, 32'hFFFF_FFFC, JP, 0, 0, JM, 32'hFFFF_FFFC, 1, 0, 9, 6, 1));
        vecs.push_back(mk(1, 3'd0, 32'd5, JR, JD, JP, 0, 0, JM, 32'h0, 0, 0, 9, 6, 1));
        vecs.push_back(mk(1, 3'd4, 32'd7, JR, JD, JP, 0, 0, JM, 32'h4, 0, 0, 10, 6, 1));

        tick();
        tick();
        checkReset("reset");
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkVector(vecs[i], i);
        end

        // Asynchronous reset while a memory target is pending, then stale mem_valid.
        en = 1'b1; mode = 3'd3; mem_valid = 1'b0;
        tick();
        checkOutput("wait mem_req", 64'(mem_req), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("async reset");
        en = 1'b0; mem_valid = 1'b1; memout = 32'h500;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checkOutput("post-reset pc hold", 64'(pc), 64'h0);
        checkOutput("post-reset taken", 64'(taken), 64'h0);
        checkOutput("post-reset mem_req", 64'(mem_req), 64'h0);
        en = 1'b1; mode = 3'd0;
        tick();
        checkOutput("first en pc", 64'(pc), 64'h4);

        // Counter saturation on the narrow-counter instance.
        doReset();
        for (int k = 0; k < 4; k++) begin
            en = 1'b1; mode = 3'd1; aluout = 32'd0; mem_valid = 1'b0;
            reg1 = 32'h40 * (k + 1);
            tick();
            checkOutput($sformatf("sat taken%0d", k), 64'(sTaken), 64'h1);
        end
        checkOutput("sat taken_cnt", 64'(sTakenCnt), 64'h3);
        checkOutput("sat branch_cnt", 64'(sBranchCnt), 64'h3);
        checkOutput("wide taken_cnt", 64'(taken_cnt), 64'h4);
        checkOutput("sat pc", 64'(sPc), 64'h100);

        // Randomized traffic against the reference model.
        doReset();
        mPc = 32'h0; mWait = 0; mTakenOut = 0; mAlign = 0; mBr = 0; mTk = 0;
        for (int c = 0; c < 600; c++) begin
            en = ($urandom_range(0, 9) < 8);
            mode = 3'($urandom_range(0, 7));
            aluout = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom);
            reg1 = randTarget();
            direct = randTarget();
            pcimm = randTarget();
            memout = randTarget();
            zero_branch = 1'($urandom_range(0, 1));
            mem_valid = ($urandom_range(0, 9) < 4);
            modelStep();
            tick();
            checkModel(c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
